// File: rtl/can_tx_pkg.sv
// Shared types and field constants for the CAN frame transmitter.
// CRC constants are only consumed when CAN_TX_CRC_EN is defined.
package can_tx_pkg;

  typedef enum logic [2:0] {
    s_idle,
    s_load,
    s_field,
    s_stuff,
    s_crc,
    s_done
  } txState_t;

  localparam int unsigned SOF_LEN    = 1;
  localparam int unsigned ID_LEN     = 11;
  localparam int unsigned CTRL_LEN   = 3;
  localparam int unsigned DLC_LEN    = 4;
  localparam int unsigned HEADER_LEN = SOF_LEN + ID_LEN + CTRL_LEN + DLC_LEN;
  localparam int unsigned STUFF_RUN  = 5;
  localparam int unsigned CRC_LEN    = 15;
  localparam logic [14:0] CRC_POLY   = 15'h4599;

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 register: one bit per bitValid, MSB-first polynomial division.
module can_crc15
  import can_tx_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               bitValid,
  input  logic               bitIn,
  output logic [CRC_LEN-1:0] crc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (bitValid) begin
      crc <= {crc[CRC_LEN-2:0], 1'b0} ^ ((bitIn ^ crc[CRC_LEN-1]) ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/can_frame_tx.sv
// CAN standard-frame serializer with bit stuffing (SOF..data field).
// Optional CRC-15 field appended when CAN_TX_CRC_EN is defined.
module can_frame_tx
  import can_tx_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 8,
  parameter int unsigned CNT_W     = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [10:0] id,
  input  logic        rtr,
  input  logic [3:0]  dlc,
  input  logic [63:0] data,
  input  logic        bitPulse,
  output logic        dOut,
  output logic        busy,
  output logic        stuffBit,
  output logic        done
);

  localparam int unsigned DATA_W  = 8 * MAX_BYTES;
  localparam int unsigned FIELD_W = HEADER_LEN + DATA_W;

  txState_t             state;
  logic [10:0]          idReg;
  logic                 rtrReg;
  logic [3:0]           dlcReg;
  logic [DATA_W-1:0]    dataReg;
  logic [FIELD_W-1:0]   fieldShift;
  logic [CNT_W-1:0]     fieldLen;
  logic [CNT_W-1:0]     bitCnt;
  logic [2:0]           runCnt;
  logic                 lastBit;

  logic [31:0]          nBytes;
  logic [CNT_W-1:0]     loadLen;
  logic [CNT_W-1:0]     bitCntInc;
  logic                 curBit;
  logic [2:0]           nextRun;

`ifdef CAN_TX_CRC_EN
  logic [CRC_LEN-1:0]   crcVal;
  logic [3:0]           crcCnt;
  logic [3:0]           crcIdx;

  can_crc15 u_crc (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == s_load),
    .bitValid ((state == s_field) && bitPulse && enable),
    .bitIn    (fieldShift[FIELD_W-1]),
    .crc      (crcVal)
  );

  assign crcIdx = 4'(CRC_LEN - 1) - crcCnt;
`endif

  always_comb begin
    nBytes = '0;
    if (!rtrReg) begin
      nBytes = (32'(dlcReg) > MAX_BYTES) ? MAX_BYTES : 32'(dlcReg);
    end
    loadLen   = CNT_W'(HEADER_LEN + 8 * nBytes);
    bitCntInc = bitCnt + CNT_W'(1);
    curBit    = fieldShift[FIELD_W-1];
`ifdef CAN_TX_CRC_EN
    if (state == s_crc) curBit = crcVal[crcIdx];
`endif
    nextRun = (curBit == lastBit) ? runCnt + 3'd1 : 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= s_idle;
      idReg      <= '0;
      rtrReg     <= 1'b0;
      dlcReg     <= '0;
      dataReg    <= '0;
      fieldShift <= '0;
      fieldLen   <= '0;
      bitCnt     <= '0;
      runCnt     <= '0;
      lastBit    <= 1'b1;
      dOut       <= 1'b1;
      busy       <= 1'b0;
      stuffBit   <= 1'b0;
      done       <= 1'b0;
`ifdef CAN_TX_CRC_EN
      crcCnt     <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (!enable && state != s_idle) begin
        state    <= s_idle;
        dOut     <= 1'b1;
        busy     <= 1'b0;
        stuffBit <= 1'b0;
        runCnt   <= '0;
      end else begin
        unique case (state)
          s_idle: begin
            if (start && enable) begin
              idReg   <= id;
              rtrReg  <= rtr;
              dlcReg  <= dlc;
              dataReg <= data[63 -: DATA_W];
              busy    <= 1'b1;
              state   <= s_load;
            end
          end
          s_load: begin
            fieldShift <= {1'b0, idReg, rtrReg, 2'b00, dlcReg, dataReg};
            fieldLen   <= loadLen;
            bitCnt     <= '0;
            runCnt     <= '0;
            lastBit    <= 1'b1;  // bus idles recessive before SOF
`ifdef CAN_TX_CRC_EN
            crcCnt     <= '0;
`endif
            state      <= s_field;
          end
          s_field: begin
            if (bitPulse) begin
              dOut       <= curBit;
              stuffBit   <= 1'b0;
              lastBit    <= curBit;
              runCnt     <= nextRun;
              fieldShift <= {fieldShift[FIELD_W-2:0], 1'b0};
              bitCnt     <= bitCntInc;
              if (nextRun == 3'(STUFF_RUN)) begin
                state <= s_stuff;
              end else if (bitCntInc == fieldLen) begin
`ifdef CAN_TX_CRC_EN
                state <= s_crc;
`else
                state <= s_done;
`endif
              end
            end
          end
          s_stuff: begin
            // Stuff bits leave bitCnt untouched, so it tells us where to resume.
            if (bitPulse) begin
              dOut     <= ~lastBit;
              stuffBit <= 1'b1;
              lastBit  <= ~lastBit;
              runCnt   <= 3'd1;
              if (bitCnt != fieldLen) begin
                state <= s_field;
`ifdef CAN_TX_CRC_EN
              end else if (crcCnt != 4'(CRC_LEN)) begin
                state <= s_crc;
`endif
              end else begin
                state <= s_done;
              end
            end
          end
          s_crc: begin
`ifdef CAN_TX_CRC_EN
            if (bitPulse) begin
              dOut     <= curBit;
              stuffBit <= 1'b0;
              lastBit  <= curBit;
              runCnt   <= nextRun;
              crcCnt   <= crcCnt + 4'd1;
              if (nextRun == 3'(STUFF_RUN)) begin
                state <= s_stuff;
              end else if (crcCnt == 4'(CRC_LEN - 1)) begin
                state <= s_done;
              end
            end
`else
            state <= s_idle;
            busy  <= 1'b0;
`endif
          end
          s_done: begin
            if (bitPulse) begin
              dOut     <= 1'b1;
              stuffBit <= 1'b0;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= s_idle;
            end
          end
          default: begin
            state <= s_idle;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_frame_tx.sv
// Directed bench for can_frame_tx: table of frames plus abort/start corner sequences.
// Expectations switch to the CRC frame layout when CAN_TX_CRC_EN is defined.
module tb_can_frame_tx;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        start;
  logic [10:0] id;
  logic        rtr;
  logic [3:0]  dlc;
  logic [63:0] data;
  logic        bitPulse;
  logic        dOut;
  logic        busy;
  logic        stuffBit;
  logic        done;

  can_frame_tx #(
    .MAX_BYTES (8),
    .CNT_W     (7)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .start    (start),
    .id       (id),
    .rtr      (rtr),
    .dlc      (dlc),
    .data     (data),
    .bitPulse (bitPulse),
    .dOut     (dOut),
    .busy     (busy),
    .stuffBit (stuffBit),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0]  id;
    logic         rtr;
    logic [3:0]   dlc;
    logic [63:0]  data;
    int           len;
    logic [127:0] bits;
    logic [127:0] stuff;
  } vec_t;

  vec_t tv[3];
  int   nVec;
  int   nCmp = 0;
  int   nErr = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic runFrame(input int v, input bit coStart, input int midStartAt,
                          input int abortAt, input string tag);
    logic [127:0] capBits;
    logic [127:0] capStuff;
    int           nBits;
    int           busyDrop;
    bit           doneSeen;
    capBits  = '0;
    capStuff = '0;
    nBits    = 0;
    busyDrop = 0;
    doneSeen = 1'b0;
    @(negedge clk);
    id       = tv[v].id;
    rtr      = tv[v].rtr;
    dlc      = tv[v].dlc;
    data     = tv[v].data;
    start    = 1'b1;
    bitPulse = coStart;
    @(negedge clk);
    start    = 1'b0;
    bitPulse = 1'b0;
    check({tag, "_busy_after_start"}, 128'(busy), 128'(1'b1));
    for (int p = 0; p < 200; p++) begin
      @(negedge clk);
      if (p == abortAt) begin
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        check({tag, "_abort_dOut"}, 128'(dOut), 128'(1'b1));
        check({tag, "_abort_busy"}, 128'(busy), 128'(1'b0));
        check({tag, "_abort_stuffBit"}, 128'(stuffBit), 128'(1'b0));
        check({tag, "_abort_done"}, 128'(done), 128'(1'b0));
        repeat (4) @(negedge clk);
        check({tag, "_abort_no_late_done"}, 128'(done), 128'(1'b0));
        return;
      end
      bitPulse = 1'b1;
      if (p == midStartAt) begin
        start = 1'b1;
        id    = ~tv[v].id;
        dlc   = 4'h3;
      end
      @(negedge clk);
      bitPulse = 1'b0;
      start    = 1'b0;
      id       = tv[v].id;
      dlc      = tv[v].dlc;
      if (done) begin
        doneSeen = 1'b1;
        check({tag, "_dOut_at_done"}, 128'(dOut), 128'(1'b1));
        check({tag, "_busy_at_done"}, 128'(busy), 128'(1'b0));
        break;
      end
      capBits  = {capBits[126:0], dOut};
      capStuff = {capStuff[126:0], stuffBit};
      nBits++;
      if (!busy) busyDrop++;
    end
    check({tag, "_done_seen"}, 128'(doneSeen), 128'(1'b1));
    @(negedge clk);
    check({tag, "_done_one_clk"}, 128'(done), 128'(1'b0));
    check({tag, "_bit_count"}, 128'(nBits), 128'(tv[v].len));
    check({tag, "_bits"}, capBits, tv[v].bits);
    check({tag, "_stuff_mask"}, capStuff, tv[v].stuff);
    check({tag, "_busy_drops"}, 128'(busyDrop), 128'(0));
  endtask

  initial begin
`ifdef CAN_TX_CRC_EN
    nVec  = 1;
    tv[0] = '{11'h000, 1'b0, 4'h0, 64'h0, 40,
              128'(40'b000001_000001_000001_000001_000001_000001_0000),
              128'(40'b000001_000001_000001_000001_000001_000001_0000)};
`else
    nVec  = 3;
    tv[0] = '{11'h000, 1'b0, 4'h0, 64'h0, 22,
              128'(22'b00000_1_00000_1_00000_1_0000),
              128'(22'b00000_1_00000_1_00000_1_0000)};
    tv[1] = '{11'h7FF, 1'b1, 4'hF, 64'h0123_4567_89AB_CDEF, 21,
              128'(21'b0_11111_0_11111_0_1_1_0_0_1111),
              128'(21'b0_00000_1_00000_1_0_0_0_0_0000)};
    tv[2] = '{11'h555, 1'b0, 4'h9, {8{8'hAA}}, 83,
              128'({1'b0, 11'h555, 3'b000, 4'b1001, {8{8'hAA}}}),
              128'(0)};
`endif
    reset    = 1'b1;
    enable   = 1'b1;
    start    = 1'b0;
    id       = '0;
    rtr      = 1'b0;
    dlc      = '0;
    data     = '0;
    bitPulse = 1'b0;
    #12;
    check("reset_dOut", 128'(dOut), 128'(1'b1));
    check("reset_busy", 128'(busy), 128'(1'b0));
    check("reset_stuffBit", 128'(stuffBit), 128'(1'b0));
    check("reset_done", 128'(done), 128'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < nVec; v++) begin
      runFrame(v, 1'b0, -1, -1, $sformatf("vec%0d", v));
      repeat (3) @(negedge clk);
    end

    // bitPulse coincident with accepted start must not consume SOF
    runFrame(0, 1'b1, -1, -1, "co_start");
    repeat (3) @(negedge clk);

    // start while busy (with changed inputs) must not disturb the frame
    runFrame(nVec - 1, 1'b0, 7, -1, "mid_start");
    repeat (3) @(negedge clk);

    // abort after 10 bit pulses, then a normal frame
    runFrame(0, 1'b0, -1, 10, "abort");
    runFrame(0, 1'b0, -1, -1, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/can_frame_tx.md
Name: can_frame_tx

Overview:
Transmit-side counterpart to the CAN receive configuration logic. Serializes a standard-format CAN frame prelude (SOF, 11-bit ID, RTR, IDE, r0, DLC) plus data field, one bit per bit-time strobe, inserting stuff bits per CAN rules. Sits between the host-side message registers and the TX pin driver. Stuffing ends at the last stuffed field; the EOF/ACK/CRC delimiters belong to the downstream block.

Parameters:
MAX_BYTES, 8, maximum data bytes sent; DLC values above this send MAX_BYTES bytes.
CNT_W, 7, width of the field bit counter; must hold 19 + 8*MAX_BYTES + 15.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  block enable; low aborts any frame in progress
start  in  1  request to transmit; sampled only in s_idle
id  in  11  standard identifier, MSB sent first
rtr  in  1  remote request; 1 forces zero data bytes
dlc  in  4  data length code, sent raw
data  in  64  payload; data[63:56] is byte 0, MSB first
bitPulse  in  1  one-clk strobe marking the start of each bit time
dOut  out  1  serialized bit; 1 = recessive
busy  out  1  frame in progress
stuffBit  out  1  high while dOut carries a stuff bit
done  out  1  one-clk pulse at frame end

Behaviour:
- Reset (async): dOut=1, busy=0, stuffBit=0, done=0, state s_idle, run counter=0, last bit=1.
- States: s_idle, s_load, s_field, s_stuff, s_crc (CRC_EN only), s_done.
- s_idle: start && enable -> latch id/rtr/dlc/data -> s_load. Start is ignored in every other state and when enable=0.
- s_load: computes nBytes = rtr ? 0 : min(dlc, MAX_BYTES) and total field length 19 + 8*nBytes. Goes to s_field on the next clk.
  - A bitPulse coincident with the accepted start is not used. SOF goes out on the first bitPulse seen in s_field.
- s_field: each bitPulse drives the next field bit on dOut. The update is registered, so it is visible the clk after bitPulse.
  - Run tracking: if the bit equals the last bit, run++; otherwise run=1.
  - When run reaches 5, the next bitPulse goes through s_stuff.
- s_stuff: drives the complement of the last bit with stuffBit=1, sets run=1 and last bit = stuff value. Stuff bits do not advance the field counter.
- After the last field bit:
  - If run==5, one trailing stuff bit is sent.
  - Then s_crc when CRC_EN is defined, otherwise s_done.
- s_done: on the next bitPulse, dOut=1 and done=1 for one clk, busy=0, then s_idle.
- busy=1 in every state other than s_idle.
- enable=0 in any non-idle state: next clk dOut=1, busy=0, stuffBit=0, done not asserted, run cleared, state s_idle.
- bitPulse is ignored in s_idle and s_load.
- Counters saturate nowhere: the field length bounds them, with no wrap-around.

Optional Feature:
Macro CAN_TX_CRC_EN.
- Defined: a CRC-15 (poly 0x4599, init 0) accumulates each field bit, excluding stuff bits, as it is sent.
  - s_crc then sends the 15 CRC bits MSB first, with stuffing continuing across the boundary.
  - The trailing-stuff rule applies after the last CRC bit.
- Undefined: no CRC logic; the frame ends after the data field.

Decomposition:
- Package can_tx_pkg:
  - state enum typedef
  - constants SOF_LEN=1, ID_LEN=11, CTRL_LEN=3, DLC_LEN=4, HEADER_LEN=19, STUFF_RUN=5, CRC_LEN=15, CRC_POLY=15'h4599
- Sub-module can_crc15: serial CRC register with clear and bit-valid inputs. Instantiated only under CAN_TX_CRC_EN.

Test Plan:
- id=0x000, rtr=0, dlc=0, no CRC -> 22 bits: 00000 1 00000 1 00000 1 0000. stuffBit high on bits 6, 12, 18; then done.
- id=0x7FF, rtr=1, dlc=0xF -> 21 bits: 0 11111 0 11111 0 1 1 0 0 1111. No data bytes.
- id=0x555, rtr=0, dlc=9, data=all 0xAA -> 83 bits, no stuff bits. Exactly 8 bytes sent, DLC field 1001.
- Frame in progress, enable dropped after 10 bitPulses -> dOut=1 next clk, busy=0, no done. A following start is accepted normally.
- start pulsed while busy -> ignored, frame unchanged. start coincident with bitPulse in s_idle -> SOF on the following bitPulse.
- CAN_TX_CRC_EN, id=0, dlc=0 -> 34 zeros with 6 stuff bits, 40 bits total. CRC field = 0x0000.
